ovi_load_packer: RTL and testbench

Packs scalar load responses from the core memory port into full-width OVI load beats for the VPU. It tags each beat with a seq_id and signals `sync_end` once the whole vector load is delivered. It sits in the OVI bridge between the core load/store response path and the VPU load/memop buses. It replaces the fixed 32-bit pass-through with a parametrised packer that supports SEW 8/16/32/64, multi-response elements and kill.

---
 rtl/ovi_pkg.sv | 47 ++++
 rtl/ovi_elem_assembler.sv | 46 ++++
 rtl/ovi_load_packer.sv | 161 ++++++++++++++++
 tb/tb_ovi_load_packer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ovi_pkg.sv
// Shared OVI bridge types: SEW codes, packer states, seq_id layout.
// Element helpers sized for the widest (64-bit) element.
package ovi_pkg;

   localparam logic [1:0] SEW_8  = 2'd0;
   localparam logic [1:0] SEW_16 = 2'd1;
   localparam logic [1:0] SEW_32 = 2'd2;
   localparam logic [1:0] SEW_64 = 2'd3;

   localparam int ELEM_W    = 64;
   localparam int SEQ_SB_W  = 5;
   localparam int SEQ_CNT_W = 7;
   localparam int SEQ_OFF_W = 6;
   localparam int SEQ_ID_W  = 11;
   localparam int SEQ_REG_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_FLUSH,
      ST_SYNC
   } state_e;

   typedef struct packed {
      logic [SEQ_SB_W-1:0]  sb_id;
      logic [SEQ_CNT_W-1:0] el_count;
      logic [SEQ_OFF_W-1:0] el_off;
      logic [SEQ_ID_W-1:0]  el_id;
      logic [SEQ_REG_W-1:0] v_reg;
   } seq_id_t;

   function automatic logic [6:0] sew_bits(input logic [1:0] sew);
      return 7'd8 << sew;
   endfunction

   function automatic logic [ELEM_W-1:0] sew_mask(input logic [1:0] sew);
      logic [ELEM_W-1:0] m;
      unique case (sew)
         SEW_8:   m = 64'hff;
         SEW_16:  m = 64'hffff;
         SEW_32:  m = 64'hffff_ffff;
         default: m = '1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ovi_elem_assembler.sv
// Merges one or two core responses into a single SEW element.
// A 64-bit element on a narrower port arrives low half first.
module ovi_elem_assembler
   import ovi_pkg::*;
#(
   parameter int RESP_W = 32
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [RESP_W-1:0] in_data,
   input  logic [1:0]        sew,
   output logic              elem_done,
   output logic [ELEM_W-1:0] elem_data
);

   localparam bit SPLIT = RESP_W < ELEM_W;

   logic              two_part;
   logic              hi_q;
   logic [RESP_W-1:0] lo_q;
   logic [ELEM_W-1:0] raw;

   assign two_part = SPLIT && (sew == SEW_64);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         hi_q <= 1'b0;
         lo_q <= '0;
      end else if (clr) begin
         hi_q <= 1'b0;
      end else if (in_valid && two_part) begin
         hi_q <= ~hi_q;
         if (!hi_q) lo_q <= in_data;
      end
   end

   always_comb begin
      elem_done = in_valid && (!two_part || hi_q);
      raw       = two_part ? ELEM_W'({in_data, lo_q})
                           : ELEM_W'(in_data);
      elem_data = raw & sew_mask(sew);
   end

endmodule

// File: rtl/ovi_load_packer.sv
// Packs scalar load responses into full-width OVI load beats,
// tags each beat with a seq_id and closes the load with sync_end.
module ovi_load_packer
   import ovi_pkg::*;
#(
   parameter int MEMDATA_W = 512,
   parameter int RESP_W    = 32,
   parameter int SBID_W    = 5,
   parameter int VL_W      = 15
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 start_valid,
   input  logic [SBID_W-1:0]    start_sb_id,
   input  logic [1:0]           start_sew,
   input  logic [VL_W-1:0]      start_vl,
   input  logic [4:0]           start_vd,
   output logic                 busy,
   output logic                 resp_ready,
   input  logic                 resp_valid,
   input  logic [RESP_W-1:0]    resp_data,
   input  logic                 kill,
   output logic                 ld_valid,
   output logic [MEMDATA_W-1:0] ld_data,
   output logic [SBID_W-1:0]    ld_sb_id,
   output logic [6:0]           ld_el_count,
   output logic [5:0]           ld_el_off,
   output logic [10:0]          ld_el_id,
   output logic [4:0]           ld_v_reg,
   output logic                 ld_mask_valid,
   output logic                 sync_end,
   output logic [SBID_W-1:0]    sync_sb_id
);

   localparam int IDW = VL_W + 8;

   state_e                 state_q, state_d;
   logic [SBID_W-1:0]      sb_q;
   logic [1:0]             sew_q;
   logic [VL_W-1:0]        vl_q;
   logic [4:0]             vd_q;
   logic [VL_W-1:0]        elem_q;
   logic [7:0]             cnt_q;
   logic [VL_W-1:0]        beat_q;
   logic [MEMDATA_W-1:0]   acc_q;

   logic                   accept;
   logic                   elem_done;
   logic [ELEM_W-1:0]      elem_data;
   logic [7:0]             epb;
   logic                   beat_full;
   logic                   last_elem;
   logic [15:0]            bit_off;
   logic [MEMDATA_W-1:0]   ext;
   logic [IDW-1:0]         id_full;
   seq_id_t                seq;

   assign accept = resp_valid && (state_q == ST_COLLECT) && !kill;

   ovi_elem_assembler #(
      .RESP_W(RESP_W)
   ) u_asm (
      .clk      (clk),
      .rst_l    (rst_l),
      .clr      (state_q != ST_COLLECT),
      .in_valid (accept),
      .in_data  (resp_data),
      .sew      (sew_q),
      .elem_done(elem_done),
      .elem_data(elem_data)
   );

   always_comb begin
      epb       = 8'((MEMDATA_W / 8) >> sew_q);
      beat_full = (cnt_q + 8'd1) == epb;
      last_elem = (elem_q + VL_W'(1)) == vl_q;
      bit_off   = 16'(cnt_q) * 16'(sew_bits(sew_q));
      ext       = MEMDATA_W'(elem_data) << bit_off;
   end

   // An empty load takes a silent FLUSH so sync lands two cycles after start.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (start_valid) begin
               state_d = (start_vl == '0) ? ST_FLUSH : ST_COLLECT;
            end
         ST_COLLECT:
            if (elem_done && (beat_full || last_elem)) begin
               state_d = ST_FLUSH;
            end
         ST_FLUSH:
            state_d = (elem_q == vl_q) ? ST_SYNC : ST_COLLECT;
         ST_SYNC:
            state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
      if (kill && (state_q != ST_IDLE)) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= ST_IDLE;
         sb_q    <= '0;
         sew_q   <= '0;
         vl_q    <= '0;
         vd_q    <= '0;
         elem_q  <= '0;
         cnt_q   <= '0;
         beat_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IDLE) && start_valid) begin
            sb_q   <= start_sb_id;
            sew_q  <= start_sew;
            vl_q   <= start_vl;
            vd_q   <= start_vd;
            elem_q <= '0;
            cnt_q  <= '0;
            beat_q <= '0;
            acc_q  <= '0;
         end
         if (elem_done) begin
            acc_q  <= acc_q | ext;
            cnt_q  <= cnt_q + 8'd1;
            elem_q <= elem_q + VL_W'(1);
         end
         if (state_q == ST_FLUSH) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            beat_q <= beat_q + VL_W'(1);
         end
      end
   end

   always_comb begin
      id_full      = IDW'(beat_q) * IDW'(epb);
      seq.sb_id    = SEQ_SB_W'(sb_q);
      seq.el_count = (cnt_q > 8'd127) ? 7'h7f : cnt_q[6:0];
      seq.el_off   = '0;
      seq.el_id    = (id_full > IDW'(2047)) ? 11'h7ff : id_full[10:0];
      seq.v_reg    = vd_q + beat_q[4:0];
   end

   assign busy          = state_q != ST_IDLE;
   assign resp_ready    = state_q == ST_COLLECT;
   assign ld_valid      = (state_q == ST_FLUSH) && (cnt_q != '0) && !kill;
   assign sync_end      = (state_q == ST_SYNC) && !kill;
   assign ld_data       = ld_valid ? acc_q : '0;
   assign ld_sb_id      = ld_valid ? SBID_W'(seq.sb_id) : '0;
   assign ld_el_count   = ld_valid ? seq.el_count : '0;
   assign ld_el_off     = seq.el_off;
   assign ld_el_id      = ld_valid ? seq.el_id : '0;
   assign ld_v_reg      = ld_valid ? seq.v_reg : '0;
   assign ld_mask_valid = 1'b0;
   assign sync_sb_id    = sync_end ? sb_q : '0;

endmodule

// File: tb/tb_ovi_load_packer.sv
// Directed bench for ovi_load_packer: beats, seq_id, sync, kill.
// Expected values are hand-computed constants per vector.
module tb_ovi_load_packer;

   localparam int MW = 512;
   localparam int RW = 32;
   localparam int SW = 5;
   localparam int VW = 15;

   logic          clk = 1'b0;
   logic          rst_l = 1'b0;
   logic          start_valid = 1'b0;
   logic [SW-1:0] start_sb_id = '0;
   logic [1:0]    start_sew = '0;
   logic [VW-1:0] start_vl = '0;
   logic [4:0]    start_vd = '0;
   logic          busy;
   logic          resp_ready;
   logic          resp_valid = 1'b0;
   logic [RW-1:0] resp_data = '0;
   logic          kill = 1'b0;
   logic          ld_valid;
   logic [MW-1:0] ld_data;
   logic [SW-1:0] ld_sb_id;
   logic [6:0]    ld_el_count;
   logic [5:0]    ld_el_off;
   logic [10:0]   ld_el_id;
   logic [4:0]    ld_v_reg;
   logic          ld_mask_valid;
   logic          sync_end;
   logic [SW-1:0] sync_sb_id;

   ovi_load_packer #(
      .MEMDATA_W(MW), .RESP_W(RW), .SBID_W(SW), .VL_W(VW)
   ) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .start_valid  (start_valid),
      .start_sb_id  (start_sb_id),
      .start_sew    (start_sew),
      .start_vl     (start_vl),
      .start_vd     (start_vd),
      .busy         (busy),
      .resp_ready   (resp_ready),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .kill         (kill),
      .ld_valid     (ld_valid),
      .ld_data      (ld_data),
      .ld_sb_id     (ld_sb_id),
      .ld_el_count  (ld_el_count),
      .ld_el_off    (ld_el_off),
      .ld_el_id     (ld_el_id),
      .ld_v_reg     (ld_v_reg),
      .ld_mask_valid(ld_mask_valid),
      .sync_end     (sync_end),
      .sync_sb_id   (sync_sb_id)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [MW-1:0] q_data[$];
   int q_cnt[$], q_id[$], q_reg[$], q_sb[$], q_cyc[$];
   int s_sb[$], s_cyc[$];

   always @(negedge clk) begin
      if (ld_valid) begin
         q_data.push_back(ld_data);
         q_cnt.push_back(int'(ld_el_count));
         q_id.push_back(int'(ld_el_id));
         q_reg.push_back(int'(ld_v_reg));
         q_sb.push_back(int'(ld_sb_id));
         q_cyc.push_back(cyc);
      end
      if (sync_end) begin
         s_sb.push_back(int'(sync_sb_id));
         s_cyc.push_back(cyc);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   int last_acc = 0;
   int t_start = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_q();
      q_data.delete(); q_cnt.delete(); q_id.delete();
      q_reg.delete(); q_sb.delete(); q_cyc.delete();
      s_sb.delete(); s_cyc.delete();
   endtask

   task automatic start(input int sb, input int sew, input int vl,
                        input int vd);
      start_valid = 1'b1;
      start_sb_id = SW'(sb);
      start_sew   = 2'(sew);
      start_vl    = VW'(vl);
      start_vd    = 5'(vd);
      t_start     = cyc;
      step();
      start_valid = 1'b0;
   endtask

   task automatic send(input logic [RW-1:0] d);
      for (int i = 0; i < 50 && !resp_ready; i++) step();
      if (!resp_ready) chk("rdy_timeout", 64'(resp_ready), 64'd1);
      resp_valid = 1'b1;
      resp_data  = d;
      step();
      last_acc   = cyc;
      resp_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && busy; i++) step();
      chk("idle_timeout", 64'(busy), 64'd0);
      step();
   endtask

   task automatic chk_beat(string t, input int i, input int cnt,
                           input int id, input int rg, input int sb);
      if (q_cnt.size() > i) begin
         chk({t, "_cnt"}, 64'(q_cnt[i]), 64'(cnt));
         chk({t, "_id"},  64'(q_id[i]),  64'(id));
         chk({t, "_reg"}, 64'(q_reg[i]), 64'(rg));
         chk({t, "_sb"},  64'(q_sb[i]),  64'(sb));
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rdy",  64'(resp_ready), 64'd0);
      chk("rst_ldv",  64'(ld_valid), 64'd0);
      chk("rst_sync", 64'(sync_end), 64'd0);
      chk("rst_data", 64'(|ld_data), 64'd0);
      rst_l = 1'b1;
      step();

      // SEW=32, vl=4
      clr_q();
      start(9, 2, 4, 7);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_rdy",  64'(resp_ready), 64'd1);
      send(32'h11111111); send(32'h22222222);
      send(32'h33333333); send(32'h44444444);
      wait_idle();
      chk("t1_nbeat", 64'(q_data.size()), 64'd1);
      chk_beat("t1", 0, 4, 0, 7, 9);
      if (q_data.size() > 0) begin
         chk("t1_lo",  q_data[0][63:0],   64'h22222222_11111111);
         chk("t1_hi",  q_data[0][127:64], 64'h44444444_33333333);
         chk("t1_up",  64'(|q_data[0][MW-1:128]), 64'd0);
         chk("t1_lat", 64'(q_cyc[0]), 64'(last_acc));
      end
      chk("t1_nsync", 64'(s_sb.size()), 64'd1);
      if (s_sb.size() > 0 && q_cyc.size() > 0) begin
         chk("t1_ssb",  64'(s_sb[0]), 64'd9);
         chk("t1_sdly", 64'(s_cyc[0] - q_cyc[0]), 64'd1);
      end

      // SEW=8, vl=130, upper response bits must be masked off
      clr_q();
      start(2, 0, 130, 3);
      for (int i = 0; i < 130; i++) send(32'hABCDEF00 | 32'(i));
      wait_idle();
      chk("t2_nbeat", 64'(q_data.size()), 64'd3);
      chk_beat("t2b0", 0, 64, 0,   3, 2);
      chk_beat("t2b1", 1, 64, 64,  4, 2);
      chk_beat("t2b2", 2, 2,  128, 5, 2);
      if (q_data.size() == 3) begin
         chk("t2_d0",  q_data[0][63:0], 64'h07060504_03020100);
         chk("t2_d0t", 64'(q_data[0][511:504]), 64'h3f);
         chk("t2_d1",  q_data[1][63:0], 64'h47464544_43424140);
         chk("t2_d2",  64'(q_data[2][15:0]), 64'h8180);
         chk("t2_d2u", 64'(|q_data[2][MW-1:16]), 64'd0);
      end
      if (s_cyc.size() > 0 && q_cyc.size() == 3) begin
         chk("t2_sdly", 64'(s_cyc[0] - q_cyc[2]), 64'd1);
      end

      // SEW=64, vl=2, lo/hi pairs
      clr_q();
      start(17, 3, 2, 30);
      send(32'h0A0B0C0D); send(32'h01020304);
      send(32'hDEADBEEF); send(32'hCAFEF00D);
      wait_idle();
      chk("t3_nbeat", 64'(q_data.size()), 64'd1);
      chk_beat("t3", 0, 2, 0, 30, 17);
      if (q_data.size() > 0) begin
         chk("t3_e0", q_data[0][63:0],   64'h01020304_0A0B0C0D);
         chk("t3_e1", q_data[0][127:64], 64'hCAFEF00D_DEADBEEF);
         chk("t3_up", 64'(|q_data[0][MW-1:128]), 64'd0);
      end

      // vl=0
      clr_q();
      start(21, 2, 0, 0);
      wait_idle();
      chk("t4_nbeat", 64'(q_data.size()), 64'd0);
      chk("t4_nsync", 64'(s_sb.size()), 64'd1);
      if (s_sb.size() > 0) begin
         chk("t4_ssb",  64'(s_sb[0]), 64'd21);
         chk("t4_sdly", 64'(s_cyc[0] - t_start), 64'd2);
      end

      // kill after 3 of 8, with a same-cycle response
      clr_q();
      start(4, 2, 8, 1);
      send(32'h1); send(32'h2); send(32'h3);
      kill = 1'b1;
      resp_valid = 1'b1;
      resp_data = 32'h77;
      step();
      kill = 1'b0;
      resp_valid = 1'b0;
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_rdy",  64'(resp_ready), 64'd0);
      repeat (4) step();
      chk("t5_nbeat", 64'(q_data.size()), 64'd0);
      chk("t5_nsync", 64'(s_sb.size()), 64'd0);
      start(6, 2, 1, 12);
      send(32'h5A);
      wait_idle();
      chk("t5_rbeat", 64'(q_data.size()), 64'd1);
      chk_beat("t5r", 0, 1, 0, 12, 6);
      if (q_data.size() > 0) begin
         chk("t5_rd", q_data[0][63:0], 64'h5A);
      end
      chk("t5_rsync", 64'(s_sb.size()), 64'd1);

      // start while busy and responses in FLUSH/SYNC are ignored
      clr_q();
      start(9, 2, 4, 7);
      start_valid = 1'b1;
      start_sb_id = 5'd31;
      start_vl = '0;
      step();
      start_valid = 1'b0;
      send(32'h11111111); send(32'h22222222);
      send(32'h33333333); send(32'h44444444);
      resp_valid = 1'b1;
      resp_data = 32'hFFFFFFFF;
      start_valid = 1'b1;
      step();
      step();
      resp_valid = 1'b0;
      start_valid = 1'b0;
      repeat (3) step();
      chk("t6_busy",  64'(busy), 64'd0);
      chk("t6_nbeat", 64'(q_data.size()), 64'd1);
      chk_beat("t6", 0, 4, 0, 7, 9);
      if (q_data.size() > 0) begin
         chk("t6_lo", q_data[0][63:0],   64'h22222222_11111111);
         chk("t6_hi", q_data[0][127:64], 64'h44444444_33333333);
      end
      chk("t6_nsync", 64'(s_sb.size()), 64'd1);
      if (s_sb.size() > 0) chk("t6_ssb", 64'(s_sb[0]), 64'd9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
